// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, opcode
// constants, fetch FSM state encoding and small decode helpers.
// Build option: FETCH_PREFETCH_EN adds a one-entry prefetch buffer
// (fetch_buf) behind the IF/ID register.
package instr_fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OPC_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [OPC_W-1:0]  opcode_t;

  // Opcode field lives in the top nibble of every instruction word
  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_LD   = 4'h8;
  localparam opcode_t OP_ST   = 4'h9;
  localparam opcode_t OP_BR   = 4'hC;
  localparam opcode_t OP_CALL = 4'hD;
  localparam opcode_t OP_RET  = 4'hE;
  localparam opcode_t OP_HLT  = 4'hF;

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_e;

  function automatic opcode_t opcode_of(input word_t w);
    return w[WORD_W-1 -: OPC_W];
  endfunction

  function automatic logic is_hlt(input word_t w);
    return opcode_of(w) == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// One-entry prefetch buffer sitting behind the IF/ID register. Holds a
// fetched word (and its link value) while IF/ID is frozen by a stall.
// Only instantiated when FETCH_PREFETCH_EN is defined.
module fetch_buf
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_plus1_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_plus1_o
);

  logic  valid_q, valid_d;
  word_t instr_q, instr_d;
  word_t pc_plus1_q, pc_plus1_d;

  // Next entry: clear beats push; a push together with a pop replaces the entry
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage with synchronous reset to empty
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus1_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, loads the IF/ID register and stops fetching after a hlt.
// Build option: FETCH_PREFETCH_EN keeps fetching during a stall into a
// one-entry buffer (fetch_buf) that drains into IF/ID on stall release.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              im_rd_en,
  output logic [WORD_W-1:0] im_addr,
  input  logic              im_rdy,
  input  logic [WORD_W-1:0] im_data,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc_plus1,
  output logic              if_valid,
  output logic              halted
);

  fetch_state_e state_q;
  logic         halted_q;

  word_t pc_q, pc_d;
  word_t ifid_instr_q, ifid_instr_d;
  word_t ifid_pc1_q, ifid_pc1_d;
  logic  ifid_valid_q, ifid_valid_d;

  logic  redirect_eff;
  logic  ifid_held;
  logic  buf_free;
  logic  rd_en;
  logic  fire;
  logic  hlt_seen;
  word_t pc_inc;

  logic  buf_valid;
  word_t buf_instr;
  word_t buf_pc1;

  assign pc_inc       = pc_q + 16'd1;
  assign redirect_eff = redirect && (state_q == S_FETCH);
  // IF/ID cannot accept a new word while a live instruction is stalled in it
  assign ifid_held    = stall && ifid_valid_q;

`ifdef FETCH_PREFETCH_EN
  logic buf_push;
  logic buf_pop;

  // A completed word lands in the buffer when IF/ID is frozen, or when an
  // older buffered word is moving into IF/ID in the same cycle.
  assign buf_free = !buf_valid;
  assign buf_push = fire && !redirect_eff && (ifid_held || buf_valid);
  assign buf_pop  = !redirect_eff && !ifid_held && buf_valid;

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_i      (rst),
    .clr_i      (redirect_eff),
    .push_i     (buf_push),
    .pop_i      (buf_pop),
    .instr_i    (im_data),
    .pc_plus1_i (pc_inc),
    .valid_o    (buf_valid),
    .instr_o    (buf_instr),
    .pc_plus1_o (buf_pc1)
  );
`else
  assign buf_free  = 1'b0;
  assign buf_valid = 1'b0;
  assign buf_instr = '0;
  assign buf_pc1   = '0;
`endif

  // Request/completion qualification; reset cycle never requests
  always_comb begin
    rd_en    = !rst && (state_q == S_FETCH) && !(ifid_held && !buf_free);
    fire     = rd_en && im_rdy;
    hlt_seen = fire && !redirect_eff && is_hlt(im_data);
  end

  // Next PC and IF/ID contents; redirect overrides everything else.
  // The buffered word (older) takes IF/ID ahead of a fresh completion.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc1_d   = ifid_pc1_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect_eff) begin
      pc_d         = redirect_pc;
      ifid_valid_d = 1'b0;
    end else begin
      if (fire) begin
        pc_d = pc_inc;
      end
      if (!ifid_held) begin
        if (buf_valid) begin
          ifid_instr_d = buf_instr;
          ifid_pc1_d   = buf_pc1;
          ifid_valid_d = 1'b1;
        end else if (fire) begin
          ifid_instr_d = im_data;
          ifid_pc1_d   = pc_inc;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_valid_d = 1'b0;
        end
      end
    end
  end

  // PC and IF/ID register update
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // FETCH/HALTED control; only reset leaves HALTED
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (hlt_seen) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          state_q  <= S_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= S_FETCH;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign im_rd_en    = rd_en;
  assign im_addr     = pc_q;
  assign if_instr    = ifid_instr_q;
  assign if_pc_plus1 = ifid_pc1_q;
  assign if_valid    = ifid_valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
- REQ-001: Parameter RESET_PC, default 16'h0000, word address loaded into the PC on reset.
- REQ-002: Port clk, input, 1, single clock; all state updates on the rising edge.
- REQ-003: Port rst, input, 1, reset, synchronous and active-high.
- REQ-004: Port stall, input, 1, hazard hold; IF/ID must not advance while asserted.
- REQ-005: Port redirect, input, 1, taken branch, call or ret from a later stage.
- REQ-006: Port redirect_pc, input, 16, target word address, valid when redirect=1.
- REQ-007: Port im_rd_en, output, 1, instruction memory read request.
- REQ-008: Port im_addr, output, 16, word address of the request; equals the PC.
- REQ-009: Port im_rdy, input, 1, memory response strobe; im_data is valid this cycle.
- REQ-010: Port im_data, input, 16, fetched instruction word.
- REQ-011: Port if_instr, output, 16, IF/ID instruction; bits [15:12] drive the control unit opcode input.
- REQ-012: Port if_pc_plus1, output, 16, address of the fetched word plus 1; used as the call link value.
- REQ-013: Port if_valid, output, 1, IF/ID holds a live instruction.
- REQ-014: Port halted, output, 1, a hlt (opcode 4'hF) has been fetched; fetching has stopped.

Function
- REQ-015: The block SHALL implement a two-state FSM, FETCH and HALTED.
- REQ-016: In FETCH, im_rd_en SHALL be 1 unless the output register is held by stall and no free buffer exists; im_addr SHALL equal pc.
- REQ-017: A fetch completes in the cycle where im_rd_en=1 and im_rdy=1; im_rdy with im_rd_en=0 SHALL be ignored.
- REQ-018: On completion without redirect, the next edge SHALL set if_instr=im_data, if_pc_plus1=pc+1, if_valid=1 and pc=pc+1.
- REQ-019: PC arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
- REQ-020: While stall=1, the IF/ID contents SHALL be held unchanged.
- REQ-021: redirect has priority over stall, completion and halt detection. Next edge: pc=redirect_pc, if_valid=0, any same-cycle response discarded, buffer cleared.
- REQ-022: If the IF/ID register is not reloaded and stall=0, if_valid SHALL fall to 0 after consumption, i.e. a bubble.
- REQ-023: A completed word with im_data[15:12]=4'hF and no redirect SHALL be delivered to IF/ID. The FSM SHALL enter HALTED, pc stays at the hlt address+1, and halted=1 from the next edge.
- REQ-024: In HALTED, im_rd_en SHALL be 0 and redirect ignored; only rst leaves HALTED.
- REQ-025: After the hlt word is consumed (stall=0), if_valid SHALL drop to 0 and remain 0.

Reset
- REQ-026: When rst=1 at an edge: pc=RESET_PC, FSM=FETCH, if_valid=0, if_instr=16'h0000, if_pc_plus1=16'h0000, halted=0, buffer empty.
- REQ-027: During the rst=1 cycle, im_rd_en SHALL be 0. A response to a request in flight before reset SHALL be ignored.
- REQ-028: The first request SHALL issue the cycle after rst deasserts.

Configuration
- REQ-029: Macro FETCH_PREFETCH_EN enables a one-entry prefetch buffer.
- REQ-030: With FETCH_PREFETCH_EN defined:
  - While stall=1 and the buffer is empty, fetching continues; a completion fills the buffer and advances pc.
  - im_rd_en drops only when both IF/ID and the buffer are full.
  - On stall release, the buffer moves to IF/ID on the next edge.
  - Halt detection applies when the word enters the buffer.
- REQ-031: Without the macro, no buffer exists; stall with if_valid=1 forces im_rd_en=0.

Structure
- REQ-032: A shared package SHALL hold the 4-bit opcode constants (including OP_HLT=4'hF), the FSM state encoding and the 16-bit word width.
- REQ-033: The prefetch buffer SHALL be a sub-module, fetch_buf, instantiated only under FETCH_PREFETCH_EN.

Verification
- REQ-034: Reset, then memory returns 16'h0123, 16'h2456, 16'h8789 with im_rdy=1 each cycle -> im_addr 0,1,2; if_instr follows one cycle later; if_pc_plus1 = 1,2,3.
- REQ-035: im_rdy delayed 3 cycles on address 5 -> im_rd_en and im_addr=5 held 3 cycles; if_valid=0 meanwhile; pc=6 after completion.
- REQ-036: redirect=1, redirect_pc=16'h0040 in the same cycle as a completion at address 7 -> word discarded, if_valid=0, next im_addr=16'h0040.
- REQ-037: stall held 4 cycles with if_instr=16'h1234 -> IF/ID unchanged. Without macro: im_rd_en=0. With macro: exactly one extra fetch, then im_rd_en=0.
- REQ-038: Word 16'hF000 fetched at address 16'h0010 -> halted=1, im_rd_en=0 permanently, pc=16'h0011; redirect ignored until rst.
- REQ-039: pc=16'hFFFF completes -> next im_addr=16'h0000. rst asserted mid-wait -> pc=RESET_PC and the late im_rdy is ignored.
